// File: rtl/led_blink_ctrl.sv
// Command-driven status LED sequencer: accepts on/off/repeat patterns over valid/ready
// and plays them in prescaled ticks, reporting busy and a one-cycle done pulse.
module led_blink_ctrl #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned TICK_FREQ = 10,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_on_ticks,
  input  logic [CNT_W-1:0] cmd_off_ticks,
  input  logic [CNT_W-1:0] cmd_repeat,
  input  logic             abort,
  output logic             led,
  output logic             busy,
  output logic             done
);

  localparam int unsigned TICK_DIV = CLK_FREQ / TICK_FREQ;
  localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1'b1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] on_q, on_d;
  logic [CNT_W-1:0] off_q, off_d;
  logic             inf_q, inf_d;
  logic             led_q, led_d;
  logic             done_q, done_d;
  logic             tick_s;
  logic             accept_s;

  function automatic logic [CNT_W-1:0] clamp_one(input logic [CNT_W-1:0] v);
    if (v == CNT_ZERO) begin
      return CNT_ONE;
    end else begin
      return v;
    end
  endfunction

  assign cmd_ready = (state_q == ST_IDLE) && !abort;
  assign accept_s  = cmd_valid && cmd_ready;
  assign tick_s    = (pre_q == PRE_LAST);
  assign led       = led_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

  // Next-state logic: abort outranks every tick-driven transition, including completion.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    phase_d = phase_q;
    rep_d   = rep_q;
    on_d    = on_q;
    off_d   = off_q;
    inf_d   = inf_q;
    led_d   = led_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        led_d = 1'b0;
        pre_d = PRE_ZERO;
        if (accept_s) begin
          state_d = ST_ON;
          led_d   = 1'b1;
          on_d    = clamp_one(cmd_on_ticks);
          off_d   = clamp_one(cmd_off_ticks);
          phase_d = clamp_one(cmd_on_ticks);
          rep_d   = cmd_repeat;
          inf_d   = (cmd_repeat == CNT_ZERO);
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ON: begin
        if (abort) begin
          state_d = ST_IDLE;
          led_d   = 1'b0;
          pre_d   = PRE_ZERO;
        end else if (tick_s) begin
          pre_d = PRE_ZERO;
          if (phase_q == CNT_ONE) begin
            state_d = ST_OFF;
            led_d   = 1'b0;
            phase_d = off_q;
          end else if (phase_q > CNT_ONE) begin
            phase_d = phase_q - CNT_ONE;
          end else begin
            phase_d = phase_q;
          end
        end else begin
          pre_d = pre_q + PRE_ONE;
        end
      end

      ST_OFF: begin
        if (abort) begin
          state_d = ST_IDLE;
          led_d   = 1'b0;
          pre_d   = PRE_ZERO;
        end else if (tick_s) begin
          pre_d = PRE_ZERO;
          if (phase_q == CNT_ONE) begin
            if (inf_q || (rep_q > CNT_ONE)) begin
              if (!inf_q) begin
                rep_d = rep_q - CNT_ONE;
              end else begin
                rep_d = rep_q;
              end
              state_d = ST_ON;
              led_d   = 1'b1;
              phase_d = on_q;
            end else begin
              state_d = ST_IDLE;
              led_d   = 1'b0;
              done_d  = 1'b1;
            end
          end else if (phase_q > CNT_ONE) begin
            phase_d = phase_q - CNT_ONE;
          end else begin
            phase_d = phase_q;
          end
        end else begin
          pre_d = pre_q + PRE_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        led_d   = 1'b0;
        pre_d   = PRE_ZERO;
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pre_q   <= PRE_ZERO;
      phase_q <= CNT_ZERO;
      rep_q   <= CNT_ZERO;
      on_q    <= CNT_ZERO;
      off_q   <= CNT_ZERO;
      inf_q   <= 1'b0;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      phase_q <= phase_d;
      rep_q   <= rep_d;
      on_q    <= on_d;
      off_q   <= off_d;
      inf_q   <= inf_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Bench for led_blink_ctrl: directed scenarios plus random commands, all checked every
// cycle against an elapsed-time model of the pattern.
module tb_led_blink_ctrl;

  localparam int D     = 10;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_on_ticks;
  logic [CNT_W-1:0] cmd_off_ticks;
  logic [CNT_W-1:0] cmd_repeat;
  logic             abort;
  logic             led;
  logic             busy;
  logic             done;

  int vectors     = 0;
  int miscompares = 0;

  // Model: cycles elapsed since the accepting edge decide everything.
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  int m_k      = 0;
  int m_on     = 1;
  int m_off    = 1;
  int m_rep    = 0;

  always #5 clk = ~clk;

  led_blink_ctrl #(.CLK_FREQ(100), .TICK_FREQ(10), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_on_ticks (cmd_on_ticks),
    .cmd_off_ticks(cmd_off_ticks),
    .cmd_repeat   (cmd_repeat),
    .abort        (abort),
    .led          (led),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit exp_led();
    int period;
    period = (m_on + m_off) * D;
    return m_active && ((m_k % period) < (m_on * D));
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_done   = 1'b0;
    m_k      = 0;
  endtask

  task automatic model_step();
    m_done = 1'b0;
    if (rst) begin
      model_reset();
    end else if (m_active) begin
      if (abort) begin
        m_active = 1'b0;
      end else begin
        m_k++;
        if (m_rep != 0 && m_k == m_rep * (m_on + m_off) * D) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end else if (cmd_valid && !abort) begin
      m_active = 1'b1;
      m_k      = 0;
      m_on     = (cmd_on_ticks == 0) ? 1 : int'(cmd_on_ticks);
      m_off    = (cmd_off_ticks == 0) ? 1 : int'(cmd_off_ticks);
      m_rep    = int'(cmd_repeat);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("led", int'(led), int'(exp_led()));
      check("busy", int'(busy), int'(m_active));
      check("done", int'(done), int'(m_done));
      check("cmd_ready", int'(cmd_ready), int'(!m_active && !abort));
    end
  end

  task automatic step(input bit v, input bit a, input int on, input int off, input int rep);
    cmd_valid     = v;
    abort         = a;
    cmd_on_ticks  = CNT_W'(on);
    cmd_off_ticks = CNT_W'(off);
    cmd_repeat    = CNT_W'(rep);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic rnd_fields(output int on, output int off, output int rep);
    on  = int'($urandom_range(0, 3));
    off = int'($urandom_range(0, 3));
    rep = int'($urandom_range(0, 3));
  endtask

  initial begin
    int i;
    int led_hi;
    int toggles;
    bit prev;
    int ron, roff, rrep;

    rst = 1'b1;
    step(1'b0, 1'b0, 0, 0, 0);
    step(1'b0, 1'b0, 0, 0, 0);
    rst = 1'b0;
    #1;
    check("reset_led", int'(led), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_ready", int'(cmd_ready), 1);
    step(1'b0, 1'b0, 0, 0, 0);

    // Basic pattern with cmd_valid held and fields scrambled mid-pattern.
    step(1'b1, 1'b0, 2, 3, 2);
    i = 0;
    led_hi = 0;
    while (!done && i < 300) begin
      led_hi += int'(led);
      rnd_fields(ron, roff, rrep);
      step(1'b1, 1'b0, ron, roff, rrep);
      i++;
    end
    check("basic_done_cycle", i, 100);
    check("basic_led_high", led_hi, 40);
    check("basic_ready_on_done", int'(cmd_ready), 1);
    step(1'b1, 1'b0, 1, 1, 1);
    check("back_to_back_busy", int'(busy), 1);
    step(1'b0, 1'b1, 0, 0, 0);
    step(1'b0, 1'b0, 0, 0, 0);

    // Zero fields clamp to one tick.
    step(1'b1, 1'b0, 0, 0, 1);
    i = 0;
    led_hi = 0;
    while (!done && i < 100) begin
      led_hi += int'(led);
      step(1'b0, 1'b0, 0, 0, 0);
      i++;
    end
    check("zero_done_cycle", i, 20);
    check("zero_led_high", led_hi, 10);
    step(1'b0, 1'b0, 0, 0, 0);

    // Infinite repeat, then abort mid-ON.
    step(1'b1, 1'b0, 1, 1, 0);
    toggles = 0;
    prev = led;
    for (int k = 0; k < 105; k++) begin
      step(1'b0, 1'b0, 0, 0, 0);
      if (led != prev) toggles++;
      prev = led;
    end
    check("inf_toggles", toggles, 10);
    check("inf_led_before_abort", int'(led), 1);
    step(1'b0, 1'b1, 0, 0, 0);
    check("abort_led", int'(led), 0);
    check("abort_busy", int'(busy), 0);
    abort = 1'b0;
    #1;
    check("abort_ready_after", int'(cmd_ready), 1);
    step(1'b0, 1'b0, 0, 0, 0);

    // abort beats cmd_valid in IDLE.
    step(1'b1, 1'b1, 2, 2, 1);
    check("conflict_idle_busy", int'(busy), 0);
    check("conflict_idle_led", int'(led), 0);
    step(1'b0, 1'b0, 0, 0, 0);

    // abort on the completion edge suppresses done.
    step(1'b1, 1'b0, 1, 1, 1);
    for (int k = 0; k < 19; k++) step(1'b0, 1'b0, 0, 0, 0);
    check("pre_completion_busy", int'(busy), 1);
    step(1'b0, 1'b1, 0, 0, 0);
    check("abort_completion_done", int'(done), 0);
    check("abort_completion_busy", int'(busy), 0);
    step(1'b0, 1'b0, 0, 0, 0);

    // Asynchronous reset mid-ON.
    step(1'b1, 1'b0, 3, 3, 1);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 0, 0, 0);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_led", int'(led), 0);
    check("async_rst_busy", int'(busy), 0);
    step(1'b0, 1'b0, 0, 0, 0);
    step(1'b0, 1'b0, 0, 0, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", int'(cmd_ready), 1);
    step(1'b1, 1'b0, 1, 1, 1);
    i = 0;
    while (!done && i < 100) begin
      step(1'b0, 1'b0, 0, 0, 0);
      i++;
    end
    check("post_rst_done_cycle", i, 20);

    // Random commands, aborts and field noise.
    for (int k = 0; k < 4000; k++) begin
      rnd_fields(ron, roff, rrep);
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 79) == 0), ron, roff, rrep);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_blink_ctrl.md
Name: led_blink_ctrl

Overview:
- Command-driven sequencer for the board status LED. Replaces the free-running LED toggler wherever software or other blocks need controlled blink patterns.
- Accepts one pattern per command over a valid/ready handshake. A pattern is on-time, off-time and repeat count, all in ticks.
- Generates the tick internally from a clock prescaler, drives the LED through ON/OFF phases, and reports busy/done.
- Sits between control logic (FSMs, UART command decoder) and the LED pin.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- TICK_FREQ, 10: pattern time base in Hz. TICK_DIV = CLK_FREQ/TICK_FREQ clocks per tick. TICK_DIV must be >= 2.
- CNT_W, 8: width of on/off/repeat command fields.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_on_ticks  in  CNT_W  LED-on duration in ticks; 0 is treated as 1.
- cmd_off_ticks  in  CNT_W  LED-off duration in ticks; 0 is treated as 1.
- cmd_repeat  in  CNT_W  number of on/off cycles; 0 means infinite until abort.
- abort  in  1  stop the current pattern.
- led  out  1  LED drive, registered.
- busy  out  1  pattern in progress (state != IDLE).
- done  out  1  one-cycle pulse on natural completion.

Behaviour:
- Reset (async, any time including mid-pattern):
  - state=IDLE; led=0, busy=0, done=0.
  - Prescaler, phase counter and repeat counter all cleared.
  - cmd_ready=1 once rst deasserts.
- cmd_ready:
  - Combinational: (state==IDLE) && !abort.
  - Accept = cmd_valid && cmd_ready at a rising edge. The command fields are latched at that edge.
  - Fields are ignored when not accepted.
- States:
  - IDLE: led=0.
    - On accept: go to ON; led=1 from the same edge.
    - Prescaler cleared to 0, phase_cnt = max(on,1), rep_cnt = cmd_repeat, inf = (cmd_repeat==0).
  - ON: led=1.
    - Prescaler counts 0..TICK_DIV-1 and wraps. tick is high in the cycle prescaler==TICK_DIV-1.
    - On tick with phase_cnt==1: go to OFF, led=0, phase_cnt = max(off,1), prescaler wraps to 0.
    - On tick otherwise: phase_cnt decrements.
  - OFF: led=0. Same tick/phase rules as ON.
    - At end of phase with inf=1, or with rep_cnt>1: decrement rep_cnt (unless inf), go to ON, led=1, phase_cnt = max(on,1).
    - At end of phase with rep_cnt==1: go to IDLE, done=1 for exactly one cycle.
- Timing:
  - The ON phase lasts exactly max(on,1)*TICK_DIV cycles. The OFF phase lasts exactly max(off,1)*TICK_DIV cycles.
  - There are no gap cycles between phases or repeats.
  - Total pattern time = rep*(on+off)*TICK_DIV cycles.
- abort:
  - In ON or OFF: go to IDLE at the next edge, led=0, prescaler cleared, done stays 0.
  - In IDLE: blocks acceptance (cmd_ready=0) and has no other effect.
  - abort together with cmd_valid in IDLE: abort wins, nothing accepted.
  - abort in the same cycle as a natural completion: abort wins, done=0.
- After a done pulse, cmd_ready=1 in the same cycle. A new command can be accepted at the next edge, giving back-to-back patterns with one IDLE cycle between them.
- Widths:
  - Prescaler width is $clog2(TICK_DIV).
  - phase_cnt and rep_cnt are CNT_W bits and never wrap. They are decremented only when >1, and rep_cnt only when !inf.

Test Plan:
- Basic pattern (TICK_DIV=10): accept on=2, off=3, rep=2 at edge E0 -> led=1 over E0..E20, 0 over E20..E50, 1 over E50..E70, 0 over E70..E100. done=1 for one cycle after E100. busy=1 over E0..E100. cmd_ready=0 in between.
- Zero clamping: accept on=0, off=0, rep=1 -> led high 10 cycles, low 10 cycles, done after 20 cycles.
- Infinite + abort: rep=0, on=1, off=1 -> led toggles every 10 cycles for >=5 periods with no done. abort asserted mid-ON phase -> led=0 and busy=0 next edge, done never pulses, cmd_ready=1 after abort drops.
- Handshake: cmd_valid held high while busy -> no acceptance. New fields changed mid-pattern have no effect on timing. Back-to-back command accepted the cycle after the done pulse.
- Conflicts:
  - abort with cmd_valid in IDLE -> not accepted, led=0.
  - abort on the completion cycle -> done=0.
- Reset: rst pulsed asynchronously (between edges) mid-ON -> led=0, busy=0 immediately. After release, cmd_ready=1 and a fresh on=1, off=1, rep=1 command completes in 20 cycles.
